// File: rtl/mem_boot_loader_if.sv
// rtl/mem_boot_loader_if.sv - byte stream handshake carrying the boot frame
interface mem_boot_loader_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   modport master (output rx_data, output rx_valid, input rx_ready);
   modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/mem_boot_loader.sv
// rtl/mem_boot_loader.sv - framed program loader that holds the core in reset until a verified image is in memory
module mem_boot_loader #(
   parameter int DEPTH_WORDS = 64
) (
   input  logic                clk,
   input  logic                reset,
   mem_boot_loader_if.slave    rx,
   input  logic                cpu_MemWrite,
   input  logic [31:0]         cpu_Adr,
   input  logic [31:0]         cpu_WriteData,
   output logic                mem_we,
   output logic [31:0]         mem_a,
   output logic [31:0]         mem_wd,
   output logic                cpu_reset,
   output logic                done,
   output logic                err,
   output logic [7:0]          word_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_WRITE, S_CHECK, S_RUN, S_ERROR
   } state_t;

   localparam logic [7:0] MAX_N = 8'(DEPTH_WORDS);

   state_t     state, state_nxt;
   logic [7:0] n;
   logic [1:0] byte_idx;
   logic [7:0] word_idx;
   logic [7:0] csum;
   logic [31:0] word_buf;
   logic       accept;
   logic       hdr_ok;

   assign rx.rx_ready = (state == S_IDLE) || (state == S_LOAD) || (state == S_CHECK);
   assign accept      = rx.rx_valid && rx.rx_ready;
   assign hdr_ok      = (rx.rx_data != 8'd0) && (rx.rx_data <= MAX_N);
   assign word_count  = word_idx;

   always_comb begin
      state_nxt = state;
      mem_we    = 1'b0;
      mem_a     = 32'd0;
      mem_wd    = 32'd0;
      case (state)
         S_IDLE: begin
            if (accept) state_nxt = hdr_ok ? S_LOAD : S_ERROR;
         end
         S_LOAD: begin
            if (accept && byte_idx == 2'd3) state_nxt = S_WRITE;
         end
         S_WRITE: begin
            mem_we    = 1'b1;
            mem_a     = {22'd0, word_idx, 2'b00};
            mem_wd    = word_buf;
            state_nxt = (word_idx == n - 8'd1) ? S_CHECK : S_LOAD;
         end
         S_CHECK: begin
            if (accept) state_nxt = (rx.rx_data == csum) ? S_RUN : S_ERROR;
         end
         S_RUN: begin
            // The core owns the memory port once the image is verified.
            mem_we = cpu_MemWrite;
            mem_a  = cpu_Adr;
            mem_wd = cpu_WriteData;
         end
         default: state_nxt = S_ERROR;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         cpu_reset <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nxt;
         cpu_reset <= (state_nxt != S_RUN);
         done      <= (state_nxt == S_RUN);
         err       <= (state_nxt == S_ERROR);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         n        <= 8'd0;
         byte_idx <= 2'd0;
         word_idx <= 8'd0;
         csum     <= 8'd0;
         word_buf <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept && hdr_ok) begin
                  n        <= rx.rx_data;
                  byte_idx <= 2'd0;
                  word_idx <= 8'd0;
                  csum     <= 8'd0;
               end
            end
            S_LOAD: begin
               if (accept) begin
                  // Little-endian: lane 0 holds the first byte of the word.
                  word_buf[{byte_idx, 3'b000} +: 8] <= rx.rx_data;
                  csum     <= csum ^ rx.rx_data;
                  byte_idx <= byte_idx + 2'd1;
               end
            end
            S_WRITE: begin
               word_idx <= word_idx + 8'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_boot_loader.sv
// tb/tb_mem_boot_loader.sv - directed self-checking bench for mem_boot_loader
module tb_mem_boot_loader;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_MemWrite;
   logic [31:0] cpu_Adr;
   logic [31:0] cpu_WriteData;
   logic        mem_we;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic        cpu_reset;
   logic        done;
   logic        err;
   logic [7:0]  word_count;

   int tests = 0;
   int failed = 0;

   logic [31:0] wr_a[$];
   logic [31:0] wr_d[$];

   logic [7:0] good_frame [0:9] = '{8'h02, 8'h0F, 8'h00, 8'h4F, 8'hE0,
                                    8'h05, 8'h20, 8'h80, 8'hE2, 8'hE7};

   always #5 clk = ~clk;

   mem_boot_loader_if bus ();

   mem_boot_loader #(.DEPTH_WORDS(64)) dut (
      .clk           (clk),
      .reset         (rst_n),
      .rx            (bus.slave),
      .cpu_MemWrite  (cpu_MemWrite),
      .cpu_Adr       (cpu_Adr),
      .cpu_WriteData (cpu_WriteData),
      .mem_we        (mem_we),
      .mem_a         (mem_a),
      .mem_wd        (mem_wd),
      .cpu_reset     (cpu_reset),
      .done          (done),
      .err           (err),
      .word_count    (word_count)
   );

   always @(negedge clk) begin
      if (mem_we && !done) begin
         wr_a.push_back(mem_a);
         wr_d.push_back(mem_wd);
      end
   end

   task automatic do_reset();
      bus.rx_valid = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      wr_a.delete();
      wr_d.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      while (!bus.rx_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) begin
         tests++; failed++;
         $display("FAIL send_timeout: rx_ready stayed %0b, required 1", bus.rx_ready);
      end
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic test_reset();
      bus.rx_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      tests++; if (cpu_reset !== 1'b1) begin failed++; $display("FAIL rst_cpu_reset_during: got %0b need 1", cpu_reset); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tests++; if (bus.rx_ready !== 1'b1) begin failed++; $display("FAIL rst_rx_ready: got %0b need 1", bus.rx_ready); end
      tests++; if (cpu_reset !== 1'b1) begin failed++; $display("FAIL rst_cpu_reset: got %0b need 1", cpu_reset); end
      tests++; if (done !== 1'b0) begin failed++; $display("FAIL rst_done: got %0b need 0", done); end
      tests++; if (err !== 1'b0) begin failed++; $display("FAIL rst_err: got %0b need 0", err); end
      tests++; if (mem_we !== 1'b0) begin failed++; $display("FAIL rst_mem_we: got %0b need 0", mem_we); end
      tests++; if (mem_a !== 32'd0) begin failed++; $display("FAIL rst_mem_a: got %h need 0", mem_a); end
      tests++; if (mem_wd !== 32'd0) begin failed++; $display("FAIL rst_mem_wd: got %h need 0", mem_wd); end
      tests++; if (word_count !== 8'd0) begin failed++; $display("FAIL rst_word_count: got %0d need 0", word_count); end
   endtask

   task automatic test_good_load();
      do_reset();
      for (int i = 0; i < 10; i++) send_byte(good_frame[i]);
      tests++; if (cpu_reset !== 1'b0) begin failed++; $display("FAIL good_cpu_reset: got %0b need 0", cpu_reset); end
      tests++; if (done !== 1'b1) begin failed++; $display("FAIL good_done: got %0b need 1", done); end
      tests++; if (err !== 1'b0) begin failed++; $display("FAIL good_err: got %0b need 0", err); end
      tests++; if (bus.rx_ready !== 1'b0) begin failed++; $display("FAIL good_rx_ready: got %0b need 0", bus.rx_ready); end
      tests++; if (word_count !== 8'd2) begin failed++; $display("FAIL good_word_count: got %0d need 2", word_count); end
      tests++;
      if (wr_a.size() != 2) begin
         failed++; $display("FAIL good_write_count: got %0d need 2", wr_a.size());
      end else if (wr_a[0] !== 32'h0 || wr_d[0] !== 32'hE04F000F ||
                   wr_a[1] !== 32'h4 || wr_d[1] !== 32'hE2802005) begin
         failed++;
         $display("FAIL good_words: got %h@%h %h@%h need E04F000F@00000000 E2802005@00000004",
                  wr_d[0], wr_a[0], wr_d[1], wr_a[1]);
      end
      repeat (4) @(negedge clk);
      tests++; if (word_count !== 8'd2 || done !== 1'b1) begin failed++; $display("FAIL good_hold: count %0d done %0b need 2 1", word_count, done); end
   endtask

   task automatic test_bad_checksum();
      do_reset();
      for (int i = 0; i < 9; i++) send_byte(good_frame[i]);
      send_byte(8'h00);
      tests++; if (err !== 1'b1) begin failed++; $display("FAIL bad_err: got %0b need 1", err); end
      tests++; if (cpu_reset !== 1'b1) begin failed++; $display("FAIL bad_cpu_reset: got %0b need 1", cpu_reset); end
      tests++; if (bus.rx_ready !== 1'b0) begin failed++; $display("FAIL bad_rx_ready: got %0b need 0", bus.rx_ready); end
      tests++; if (done !== 1'b0) begin failed++; $display("FAIL bad_done: got %0b need 0", done); end
      tests++; if (wr_a.size() != 2) begin failed++; $display("FAIL bad_write_count: got %0d need 2", wr_a.size()); end
   endtask

   task automatic test_header_bounds();
      do_reset();
      send_byte(8'h00);
      tests++; if (err !== 1'b1 || bus.rx_ready !== 1'b0) begin failed++; $display("FAIL hdr_zero: err %0b ready %0b need 1 0", err, bus.rx_ready); end
      tests++; if (wr_a.size() != 0) begin failed++; $display("FAIL hdr_zero_writes: got %0d need 0", wr_a.size()); end
      do_reset();
      send_byte(8'h41);
      tests++; if (err !== 1'b1) begin failed++; $display("FAIL hdr_65: err %0b need 1", err); end
      tests++; if (wr_a.size() != 0) begin failed++; $display("FAIL hdr_65_writes: got %0d need 0", wr_a.size()); end
      do_reset();
      send_byte(8'h40);
      tests++; if (err !== 1'b0 || bus.rx_ready !== 1'b1) begin failed++; $display("FAIL hdr_64: err %0b ready %0b need 0 1", err, bus.rx_ready); end
   endtask

   task automatic test_flow_control();
      do_reset();
      for (int i = 0; i < 5; i++) send_byte(good_frame[i]);
      tests++; if (mem_we !== 1'b1 || bus.rx_ready !== 1'b0) begin failed++; $display("FAIL flow_write_cycle: we %0b ready %0b need 1 0", mem_we, bus.rx_ready); end
      tests++; if (mem_a !== 32'h0 || mem_wd !== 32'hE04F000F) begin failed++; $display("FAIL flow_write_data: got %h@%h need E04F000F@00000000", mem_wd, mem_a); end
      bus.rx_data  = 8'h05;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      tests++; if (mem_we !== 1'b0 || bus.rx_ready !== 1'b1 || word_count !== 8'd1) begin
         failed++; $display("FAIL flow_after_write: we %0b ready %0b count %0d need 0 1 1", mem_we, bus.rx_ready, word_count);
      end
      @(negedge clk);
      bus.rx_valid = 1'b0;
      for (int i = 6; i < 10; i++) send_byte(good_frame[i]);
      tests++; if (done !== 1'b1) begin failed++; $display("FAIL flow_done: got %0b need 1", done); end
      tests++; if (wr_d.size() != 2 || wr_d[1] !== 32'hE2802005) begin failed++; $display("FAIL flow_word1: writes %0d need 2 with E2802005", wr_d.size()); end

      do_reset();
      for (int i = 0; i < 10; i++) begin
         bus.rx_data = 8'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send_byte(good_frame[i]);
      end
      tests++; if (done !== 1'b1) begin failed++; $display("FAIL gaps_done: got %0b need 1", done); end
      tests++;
      if (wr_d.size() != 2) begin
         failed++; $display("FAIL gaps_write_count: got %0d need 2", wr_d.size());
      end else if (wr_d[0] !== 32'hE04F000F || wr_d[1] !== 32'hE2802005) begin
         failed++; $display("FAIL gaps_words: got %h %h need E04F000F E2802005", wr_d[0], wr_d[1]);
      end
   endtask

   task automatic test_reset_midload_passthrough();
      do_reset();
      for (int i = 0; i < 8; i++) send_byte(good_frame[i]);
      tests++; if (word_count !== 8'd1) begin failed++; $display("FAIL mid_count_before: got %0d need 1", word_count); end
      rst_n = 1'b0;
      #1;
      tests++; if (bus.rx_ready !== 1'b1 || word_count !== 8'd0 || mem_we !== 1'b0) begin
         failed++; $display("FAIL mid_reset_idle: ready %0b count %0d we %0b need 1 0 0", bus.rx_ready, word_count, mem_we);
      end
      @(negedge clk);
      do_reset();
      for (int i = 0; i < 10; i++) send_byte(good_frame[i]);
      tests++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin failed++; $display("FAIL mid_reload: done %0b cpu_reset %0b need 1 0", done, cpu_reset); end
      tests++; if (wr_d.size() != 2 || wr_d[0] !== 32'hE04F000F) begin failed++; $display("FAIL mid_reload_words: writes %0d need 2", wr_d.size()); end
      cpu_MemWrite  = 1'b1;
      cpu_Adr       = 32'h20;
      cpu_WriteData = 32'h12345678;
      #1;
      tests++; if (mem_we !== 1'b1 || mem_a !== 32'h20 || mem_wd !== 32'h12345678) begin
         failed++; $display("FAIL pass_write: we %0b a %h wd %h need 1 00000020 12345678", mem_we, mem_a, mem_wd);
      end
      @(negedge clk);
      cpu_MemWrite = 1'b0;
      cpu_Adr      = 32'h44;
      #1;
      tests++; if (mem_we !== 1'b0 || mem_a !== 32'h44) begin
         failed++; $display("FAIL pass_read: we %0b a %h need 0 00000044", mem_we, mem_a);
      end
   endtask

   initial begin
      bus.rx_data   = 8'h00;
      bus.rx_valid  = 1'b0;
      cpu_MemWrite  = 1'b1;
      cpu_Adr       = 32'hDEADBEE0;
      cpu_WriteData = 32'h5555AAAA;
      test_reset();
      test_good_load();
      test_bad_checksum();
      test_header_bounds();
      cpu_MemWrite  = 1'b1;
      cpu_Adr       = 32'hDEADBEE0;
      test_flow_control();
      test_reset_midload_passthrough();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
